// File: rtl/issue_queue_if.sv
// Dispatch, wakeup-broadcast and issue bundle for issue_queue. The producer side
// (rename/dispatch, result buses, FU ready lines) holds the master modport.
interface issue_queue_if #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned NUM_FU     = 3,
   parameter int unsigned NUM_WAKEUP = 4,
   parameter int unsigned TAG_W      = 6,
   parameter int unsigned DATA_W     = 32
);
   localparam int unsigned CntW = $clog2(DEPTH) + 1;

   logic                         disp_valid;
   logic                         disp_ready;
   logic [TAG_W-1:0]             disp_rd;
   logic [TAG_W-1:0]             disp_rs1;
   logic [TAG_W-1:0]             disp_rs2;
   logic [TAG_W-1:0]             disp_rob;
   logic                         disp_rs1_ready;
   logic                         disp_rs2_ready;
   logic [DATA_W-1:0]            disp_rs1_val;
   logic [DATA_W-1:0]            disp_rs2_val;
   logic [DATA_W-1:0]            disp_imm;
   logic [3:0]                   disp_alu_ctl;
   logic                         disp_alusrc;
   logic                         disp_ls;
   logic [NUM_WAKEUP-1:0]        wk_valid;
   logic [NUM_WAKEUP*TAG_W-1:0]  wk_tag;
   logic [NUM_WAKEUP*DATA_W-1:0] wk_val;
   logic [NUM_FU-1:0]            fu_ready;
   logic [NUM_FU-1:0]            iss_valid;
   logic [NUM_FU*TAG_W-1:0]      iss_rd;
   logic [NUM_FU*TAG_W-1:0]      iss_rob;
   logic [NUM_FU*DATA_W-1:0]     iss_rs1_val;
   logic [NUM_FU*DATA_W-1:0]     iss_rs2_val;
   logic [NUM_FU*DATA_W-1:0]     iss_imm;
   logic [NUM_FU*4-1:0]          iss_alu_ctl;
   logic [NUM_FU-1:0]            iss_alusrc;
   logic [NUM_FU-1:0]            iss_ls;
   logic [CntW-1:0]              count;

   modport master (
      output disp_valid, disp_rd, disp_rs1, disp_rs2, disp_rob, disp_rs1_ready, disp_rs2_ready,
             disp_rs1_val, disp_rs2_val, disp_imm, disp_alu_ctl, disp_alusrc, disp_ls,
             wk_valid, wk_tag, wk_val, fu_ready,
      input  disp_ready, iss_valid, iss_rd, iss_rob, iss_rs1_val, iss_rs2_val, iss_imm,
             iss_alu_ctl, iss_alusrc, iss_ls, count
   );

   modport slave (
      input  disp_valid, disp_rd, disp_rs1, disp_rs2, disp_rob, disp_rs1_ready, disp_rs2_ready,
             disp_rs1_val, disp_rs2_val, disp_imm, disp_alu_ctl, disp_alusrc, disp_ls,
             wk_valid, wk_tag, wk_val, fu_ready,
      output disp_ready, iss_valid, iss_rd, iss_rob, iss_rs1_val, iss_rs2_val, iss_imm,
             iss_alu_ctl, iss_alusrc, iss_ls, count
   );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: oldest-first selection per FU via an age matrix, with
// same-cycle wakeup bypass into both resident entries and the dispatch slot.
module issue_queue #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned NUM_FU     = 3,
   parameter int unsigned NUM_WAKEUP = 4,
   parameter int unsigned TAG_W      = 6,
   parameter int unsigned DATA_W     = 32
) (
   input logic          clk,
   input logic          reset,
   input logic          flush,
   issue_queue_if.slave bus
);
   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = IdxW + 1;
   localparam logic [CntW-1:0] Full = CntW'(DEPTH);

   logic [DEPTH-1:0]         r_valid, r_rs1_rdy, r_rs2_rdy, r_ls, r_alusrc;
   logic [TAG_W-1:0]         r_rd [DEPTH];
   logic [TAG_W-1:0]         r_rob [DEPTH];
   logic [TAG_W-1:0]         r_rs1 [DEPTH];
   logic [TAG_W-1:0]         r_rs2 [DEPTH];
   logic [DATA_W-1:0]        r_rs1_val [DEPTH];
   logic [DATA_W-1:0]        r_rs2_val [DEPTH];
   logic [DATA_W-1:0]        r_imm [DEPTH];
   logic [3:0]               r_alu_ctl [DEPTH];
   // r_older[i][j] set: entry j was dispatched before entry i
   logic [DEPTH-1:0]         r_older [DEPTH];
   logic [CntW-1:0]          r_count;
   logic [NUM_FU-1:0]        r_iss_valid, r_iss_alusrc, r_iss_ls;
   logic [NUM_FU*TAG_W-1:0]  r_iss_rd, r_iss_rob;
   logic [NUM_FU*DATA_W-1:0] r_iss_rs1_val, r_iss_rs2_val, r_iss_imm;
   logic [NUM_FU*4-1:0]      r_iss_alu_ctl;

   logic [DEPTH-1:0]         w_hit1, w_hit2, w_elig, w_taken, w_cand;
   logic [DATA_W:0]          w_lk1 [DEPTH];
   logic [DATA_W:0]          w_lk2 [DEPTH];
   logic [DATA_W-1:0]        w_val1 [DEPTH];
   logic [DATA_W-1:0]        w_val2 [DEPTH];
   logic [DATA_W:0]          w_dlk1, w_dlk2;
   logic [NUM_FU-1:0]        w_sel;
   logic [IdxW-1:0]          w_sel_idx [NUM_FU];
   logic [IdxW-1:0]          w_free;
   logic [CntW-1:0]          w_num_iss;
   logic                     w_accept;

   // Returns {hit, value}; the lowest-index matching port wins, tag 0 never matches.
   function automatic logic [DATA_W:0] wk_lookup(
      input logic [TAG_W-1:0]             tag,
      input logic [NUM_WAKEUP-1:0]        vld,
      input logic [NUM_WAKEUP*TAG_W-1:0]  tags,
      input logic [NUM_WAKEUP*DATA_W-1:0] vals
   );
      logic [DATA_W:0] res;
      res = '0;
      for (int p = NUM_WAKEUP - 1; p >= 0; p--) begin
         if (vld[p] && (tag != '0) && (tags[p*TAG_W +: TAG_W] == tag)) begin
            res = {1'b1, vals[p*DATA_W +: DATA_W]};
         end
      end
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_lk1[i]  = wk_lookup(r_rs1[i], bus.wk_valid, bus.wk_tag, bus.wk_val);
         w_lk2[i]  = wk_lookup(r_rs2[i], bus.wk_valid, bus.wk_tag, bus.wk_val);
         w_hit1[i] = ~r_rs1_rdy[i] & w_lk1[i][DATA_W];
         w_hit2[i] = ~r_rs2_rdy[i] & w_lk2[i][DATA_W];
         w_val1[i] = r_rs1_rdy[i] ? r_rs1_val[i] : w_lk1[i][DATA_W-1:0];
         w_val2[i] = r_rs2_rdy[i] ? r_rs2_val[i] : w_lk2[i][DATA_W-1:0];
         w_elig[i] = r_valid[i] & (r_rs1_rdy[i] | w_hit1[i]) & (r_rs2_rdy[i] | w_hit2[i]);
      end
   end

   always_comb begin
      w_taken   = '0;
      w_sel     = '0;
      w_cand    = '0;
      w_num_iss = '0;
      for (int f = 0; f < NUM_FU; f++) begin
         w_sel_idx[f] = '0;
         w_cand = w_elig & ~w_taken & ((f == NUM_FU - 1) ? r_ls : ~r_ls);
         if (bus.fu_ready[f]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (w_cand[i] && ((w_cand & r_older[i]) == '0)) begin
                  w_sel[f]     = 1'b1;
                  w_sel_idx[f] = IdxW'(i);
               end
            end
            if (w_sel[f]) w_taken[w_sel_idx[f]] = 1'b1;
         end
         w_num_iss = w_num_iss + CntW'(w_sel[f]);
      end
   end

   always_comb begin
      w_free = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free = IdxW'(i);
      end
   end

   assign bus.disp_ready = ~reset & ~flush & (r_count < Full);
   assign w_accept       = bus.disp_valid & bus.disp_ready;
   assign w_dlk1         = wk_lookup(bus.disp_rs1, bus.wk_valid, bus.wk_tag, bus.wk_val);
   assign w_dlk2         = wk_lookup(bus.disp_rs2, bus.wk_valid, bus.wk_tag, bus.wk_val);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid       <= '0;
         r_count       <= '0;
         r_iss_valid   <= '0;
         r_iss_rd      <= '0;
         r_iss_rob     <= '0;
         r_iss_rs1_val <= '0;
         r_iss_rs2_val <= '0;
         r_iss_imm     <= '0;
         r_iss_alu_ctl <= '0;
         r_iss_alusrc  <= '0;
         r_iss_ls      <= '0;
      end else if (flush) begin
         r_valid     <= '0;
         r_count     <= '0;
         r_iss_valid <= '0;
      end else begin
         r_iss_valid <= w_sel;
         r_count     <= r_count + CntW'(w_accept) - w_num_iss;
         r_valid     <= r_valid & ~w_taken;
         for (int f = 0; f < NUM_FU; f++) begin
            if (w_sel[f]) begin
               r_iss_rd[f*TAG_W +: TAG_W]       <= r_rd[w_sel_idx[f]];
               r_iss_rob[f*TAG_W +: TAG_W]      <= r_rob[w_sel_idx[f]];
               r_iss_rs1_val[f*DATA_W +: DATA_W] <= w_val1[w_sel_idx[f]];
               r_iss_rs2_val[f*DATA_W +: DATA_W] <= w_val2[w_sel_idx[f]];
               r_iss_imm[f*DATA_W +: DATA_W]     <= r_imm[w_sel_idx[f]];
               r_iss_alu_ctl[f*4 +: 4]           <= r_alu_ctl[w_sel_idx[f]];
               r_iss_alusrc[f]                   <= r_alusrc[w_sel_idx[f]];
               r_iss_ls[f]                       <= r_ls[w_sel_idx[f]];
            end
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (w_hit1[i]) begin
               r_rs1_rdy[i] <= 1'b1;
               r_rs1_val[i] <= w_lk1[i][DATA_W-1:0];
            end
            if (w_hit2[i]) begin
               r_rs2_rdy[i] <= 1'b1;
               r_rs2_val[i] <= w_lk2[i][DATA_W-1:0];
            end
         end
         if (w_accept) begin
            r_valid[w_free]   <= 1'b1;
            r_rd[w_free]      <= bus.disp_rd;
            r_rob[w_free]     <= bus.disp_rob;
            r_rs1[w_free]     <= bus.disp_rs1;
            r_rs2[w_free]     <= bus.disp_rs2;
            r_rs1_rdy[w_free] <= bus.disp_rs1_ready | w_dlk1[DATA_W];
            r_rs2_rdy[w_free] <= bus.disp_rs2_ready | w_dlk2[DATA_W];
            r_rs1_val[w_free] <= bus.disp_rs1_ready ? bus.disp_rs1_val : w_dlk1[DATA_W-1:0];
            r_rs2_val[w_free] <= bus.disp_rs2_ready ? bus.disp_rs2_val : w_dlk2[DATA_W-1:0];
            r_imm[w_free]     <= bus.disp_imm;
            r_alu_ctl[w_free] <= bus.disp_alu_ctl;
            r_alusrc[w_free]  <= bus.disp_alusrc;
            r_ls[w_free]      <= bus.disp_ls;
            // New entry is younger than everyone; stale bits of free slots are
            // cleared here when they are reused, so no sequence counter can wrap.
            for (int j = 0; j < DEPTH; j++) r_older[j][w_free] <= 1'b0;
            r_older[w_free] <= ~(DEPTH'(1) << w_free);
         end
      end
   end

   assign bus.iss_valid   = r_iss_valid;
   assign bus.iss_rd      = r_iss_rd;
   assign bus.iss_rob     = r_iss_rob;
   assign bus.iss_rs1_val = r_iss_rs1_val;
   assign bus.iss_rs2_val = r_iss_rs2_val;
   assign bus.iss_imm     = r_iss_imm;
   assign bus.iss_alu_ctl = r_iss_alu_ctl;
   assign bus.iss_alusrc  = r_iss_alusrc;
   assign bus.iss_ls      = r_iss_ls;
   assign bus.count       = r_count;
endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: an age-ordered queue model predicts every issue
// and the occupancy; a monitor process checks the DUT outputs against those predictions.
module tb_issue_queue;
   localparam int unsigned DEPTH      = 16;
   localparam int unsigned NUM_FU     = 3;
   localparam int unsigned NUM_WAKEUP = 4;
   localparam int unsigned TAG_W      = 6;
   localparam int unsigned DATA_W     = 32;

   logic clk = 1'b0;
   logic reset, flush;
   always #5 clk = ~clk;

   issue_queue_if #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_WAKEUP(NUM_WAKEUP), .TAG_W(TAG_W),
                    .DATA_W(DATA_W)) bus ();

   issue_queue #(.DEPTH(DEPTH), .NUM_FU(NUM_FU), .NUM_WAKEUP(NUM_WAKEUP), .TAG_W(TAG_W),
                 .DATA_W(DATA_W)) dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus));

   typedef struct {
      logic [TAG_W-1:0]  rd, rs1, rs2, rob;
      bit                r1, r2;
      logic [DATA_W-1:0] v1, v2, imm;
      logic [3:0]        ctl;
      bit                alusrc, ls;
   } ent_t;

   typedef struct {
      int                ed;
      logic [TAG_W-1:0]  rd, rob;
      logic [DATA_W-1:0] v1, v2, imm;
      logic [3:0]        ctl;
      bit                alusrc, ls;
   } exp_t;

   ent_t mq[$];               // resident entries, oldest first
   exp_t exp_q[NUM_FU][$];
   int   cnt_q[$];
   int   edge_no  = 0;
   int   mon_edge = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic bit wake(input logic [TAG_W-1:0] tag, output logic [DATA_W-1:0] v);
      v = '0;
      if (tag == '0) return 1'b0;
      for (int p = 0; p < NUM_WAKEUP; p++) begin
         if (bus.wk_valid[p] && bus.wk_tag[p*TAG_W +: TAG_W] == tag) begin
            v = bus.wk_val[p*DATA_W +: DATA_W];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   // Predicts the effect of the coming edge from the inputs currently driven.
   task automatic model_step();
      ent_t              nq[$];
      ent_t              d;
      exp_t              e;
      bit                tk[DEPTH];
      bit                el[DEPTH];
      logic [DATA_W-1:0] v;
      int                n;
      edge_no++;
      n = mq.size();
      if (reset || flush) begin
         mq.delete();
      end else begin
         for (int i = 0; i < n; i++) begin
            tk[i] = 1'b0;
            if (!mq[i].r1 && wake(mq[i].rs1, v)) begin mq[i].r1 = 1'b1; mq[i].v1 = v; end
            if (!mq[i].r2 && wake(mq[i].rs2, v)) begin mq[i].r2 = 1'b1; mq[i].v2 = v; end
            el[i] = mq[i].r1 && mq[i].r2;
         end
         for (int f = 0; f < NUM_FU; f++) begin
            if (!bus.fu_ready[f]) continue;
            for (int i = 0; i < n; i++) begin
               if (el[i] && !tk[i] && (mq[i].ls == (f == NUM_FU - 1))) begin
                  e.ed = edge_no; e.rd = mq[i].rd; e.rob = mq[i].rob; e.v1 = mq[i].v1;
                  e.v2 = mq[i].v2; e.imm = mq[i].imm; e.ctl = mq[i].ctl;
                  e.alusrc = mq[i].alusrc; e.ls = mq[i].ls;
                  exp_q[f].push_back(e);
                  tk[i] = 1'b1;
                  break;
               end
            end
         end
         for (int i = 0; i < n; i++) if (!tk[i]) nq.push_back(mq[i]);
         if (bus.disp_valid && n < DEPTH) begin
            d.rd = bus.disp_rd; d.rs1 = bus.disp_rs1; d.rs2 = bus.disp_rs2; d.rob = bus.disp_rob;
            d.r1 = bus.disp_rs1_ready; d.r2 = bus.disp_rs2_ready;
            d.v1 = bus.disp_rs1_val; d.v2 = bus.disp_rs2_val; d.imm = bus.disp_imm;
            d.ctl = bus.disp_alu_ctl; d.alusrc = bus.disp_alusrc; d.ls = bus.disp_ls;
            if (!d.r1 && wake(d.rs1, v)) begin d.r1 = 1'b1; d.v1 = v; end
            if (!d.r2 && wake(d.rs2, v)) begin d.r2 = 1'b1; d.v2 = v; end
            nq.push_back(d);
         end
         mq = nq;
      end
      cnt_q.push_back(mq.size());
   endtask

   // Monitor: one pass per edge, sampled 1 time unit after it.
   initial begin
      int   c;
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         mon_edge++;
         if (cnt_q.size() > 0) begin
            c = cnt_q.pop_front();
            n_checks++;
            if (int'(bus.count) != c) begin
               n_fail++;
               $display("FAIL count edge %0d: got %0d expected %0d", mon_edge, bus.count, c);
            end
         end
         for (int f = 0; f < NUM_FU; f++) begin
            if (bus.iss_valid[f]) begin
               n_checks++;
               if (exp_q[f].size() == 0) begin
                  n_fail++;
                  $display("FAIL issue_fu%0d edge %0d: unexpected issue rob=%0d", f, mon_edge,
                           bus.iss_rob[f*TAG_W +: TAG_W]);
               end else begin
                  e = exp_q[f].pop_front();
                  if (e.ed != mon_edge || bus.iss_rd[f*TAG_W +: TAG_W] != e.rd ||
                      bus.iss_rob[f*TAG_W +: TAG_W] != e.rob ||
                      bus.iss_rs1_val[f*DATA_W +: DATA_W] != e.v1 ||
                      bus.iss_rs2_val[f*DATA_W +: DATA_W] != e.v2 ||
                      bus.iss_imm[f*DATA_W +: DATA_W] != e.imm ||
                      bus.iss_alu_ctl[f*4 +: 4] != e.ctl || bus.iss_alusrc[f] != e.alusrc ||
                      bus.iss_ls[f] != e.ls) begin
                     n_fail++;
                     $display("FAIL issue_fu%0d: got edge=%0d rd=%0d rob=%0d v1=%h v2=%h imm=%h ctl=%h src=%b ls=%b, expected edge=%0d rd=%0d rob=%0d v1=%h v2=%h imm=%h ctl=%h src=%b ls=%b",
                              f, mon_edge, bus.iss_rd[f*TAG_W +: TAG_W],
                              bus.iss_rob[f*TAG_W +: TAG_W], bus.iss_rs1_val[f*DATA_W +: DATA_W],
                              bus.iss_rs2_val[f*DATA_W +: DATA_W], bus.iss_imm[f*DATA_W +: DATA_W],
                              bus.iss_alu_ctl[f*4 +: 4], bus.iss_alusrc[f], bus.iss_ls[f],
                              e.ed, e.rd, e.rob, e.v1, e.v2, e.imm, e.ctl, e.alusrc, e.ls);
                  end
               end
            end
            while (exp_q[f].size() > 0 && exp_q[f][0].ed <= mon_edge) begin
               e = exp_q[f].pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL issue_fu%0d edge %0d: got no issue, expected rob=%0d", f, mon_edge,
                        e.rob);
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.disp_valid = 1'b0; bus.disp_rd = '0; bus.disp_rs1 = '0; bus.disp_rs2 = '0;
      bus.disp_rob = '0; bus.disp_rs1_ready = 1'b0; bus.disp_rs2_ready = 1'b0;
      bus.disp_rs1_val = '0; bus.disp_rs2_val = '0; bus.disp_imm = '0; bus.disp_alu_ctl = '0;
      bus.disp_alusrc = 1'b0; bus.disp_ls = 1'b0;
      bus.wk_valid = '0; bus.wk_tag = '0; bus.wk_val = '0;
      bus.fu_ready = '0;
      flush = 1'b0;
   endtask

   task automatic set_disp(input logic [TAG_W-1:0] rd, input logic [TAG_W-1:0] rs1, input bit r1,
                           input logic [DATA_W-1:0] v1, input logic [TAG_W-1:0] rs2,
                           input bit r2, input logic [DATA_W-1:0] v2,
                           input logic [TAG_W-1:0] rob, input bit ls);
      bus.disp_valid = 1'b1; bus.disp_rd = rd; bus.disp_rs1 = rs1; bus.disp_rs2 = rs2;
      bus.disp_rob = rob; bus.disp_rs1_ready = r1; bus.disp_rs2_ready = r2;
      bus.disp_rs1_val = v1; bus.disp_rs2_val = v2; bus.disp_imm = 32'h1000 + 32'(rd);
      bus.disp_alu_ctl = 4'b0010; bus.disp_alusrc = 1'b0; bus.disp_ls = ls;
   endtask

   task automatic set_wk(input int p, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
      bus.wk_valid[p] = 1'b1;
      bus.wk_tag[p*TAG_W +: TAG_W] = t;
      bus.wk_val[p*DATA_W +: DATA_W] = v;
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
   endtask

   function automatic bit payload_nonzero();
      return |{bus.iss_rd, bus.iss_rob, bus.iss_rs1_val, bus.iss_rs2_val, bus.iss_imm,
               bus.iss_alu_ctl, bus.iss_alusrc, bus.iss_ls};
   endfunction

   initial begin
      idle();
      reset = 1'b1;
      tick();
      tick();
      check("reset_disp_ready", bus.disp_ready, 0);
      check("reset_iss_valid", bus.iss_valid, 0);
      check("reset_payload", payload_nonzero(), 0);
      reset = 1'b0;
      #1 check("disp_ready_after_reset", bus.disp_ready, 1);

      // Basic ALU issue
      set_disp(10, 11, 1, 1, 12, 1, 2, 15, 0);
      bus.fu_ready = 3'b001;
      tick();
      bus.disp_valid = 1'b0;
      tick();
      check("alu_iss_valid", bus.iss_valid, 3'b001);
      check("alu_rs1", bus.iss_rs1_val[31:0], 1);
      check("alu_rob", bus.iss_rob[5:0], 15);
      tick();

      // Load/store goes only to the last FU
      set_disp(20, 21, 1, 3, 0, 1, 0, 2, 1);
      tick();
      bus.disp_valid = 1'b0;
      tick();
      tick();
      check("ls_blocked", bus.iss_valid, 0);
      bus.fu_ready = 3'b100;
      tick();
      check("ls_iss_valid", bus.iss_valid, 3'b100);
      check("ls_rs1", bus.iss_rs1_val[95:64], 3);

      // Wakeup and lowest-port priority
      idle();
      bus.fu_ready = 3'b001;
      set_disp(30, 31, 0, 0, 4, 1, 7, 3, 0);
      tick();
      bus.disp_valid = 1'b0;
      tick();
      check("wk_wait", bus.iss_valid, 0);
      set_wk(1, 31, 1);
      tick();
      check("wk_iss_valid", bus.iss_valid, 3'b001);
      check("wk_rs1", bus.iss_rs1_val[31:0], 1);
      idle();
      bus.fu_ready = 3'b001;
      set_disp(32, 31, 0, 0, 4, 1, 7, 4, 0);
      tick();
      bus.disp_valid = 1'b0;
      set_wk(0, 31, 32'haa);
      set_wk(2, 31, 32'hbb);
      tick();
      check("wk_prio_rs1", bus.iss_rs1_val[31:0], 32'haa);
      idle();
      tick();

      // Fill to full, then drain in age order through FU0
      for (int i = 0; i < DEPTH; i++) begin
         set_disp(TAG_W'(i + 1), 1, 1, 32'(i), 2, 1, 32'(i * 3), TAG_W'(i + 40), 0);
         tick();
      end
      check("full_count", bus.count, DEPTH);
      check("full_disp_ready", bus.disp_ready, 0);
      bus.fu_ready = 3'b001;
      tick();
      bus.disp_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) tick();
      check("drain_count", bus.count, 0);

      // Two ALUs in the same cycle, oldest on FU0
      idle();
      set_disp(50, 1, 1, 5, 2, 1, 6, 21, 0);
      tick();
      set_disp(51, 1, 1, 8, 2, 1, 9, 22, 0);
      tick();
      idle();
      bus.fu_ready = 3'b011;
      tick();
      check("dual_iss_valid", bus.iss_valid, 3'b011);
      check("dual_fu0_rob", bus.iss_rob[5:0], 21);
      check("dual_fu1_rob", bus.iss_rob[11:6], 22);

      // Flush with resident entries and a dispatch in flight
      idle();
      for (int i = 0; i < 5; i++) begin set_disp(TAG_W'(i + 1), 1, 1, 1, 2, 1, 2, 9, 0); tick(); end
      bus.fu_ready = 3'b011;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.disp_valid = 1'b0;
      check("flush_count", bus.count, 0);
      check("flush_iss_valid", bus.iss_valid, 0);
      tick();
      check("flush_dropped", bus.count, 0);

      // Reset mid-operation beats flush and dispatch
      idle();
      for (int i = 0; i < 5; i++) begin set_disp(TAG_W'(i + 1), 1, 1, 1, 2, 1, 2, 9, 0); tick(); end
      reset = 1'b1;
      flush = 1'b1;
      bus.fu_ready = 3'b111;
      tick();
      check("rst_count", bus.count, 0);
      check("rst_iss_valid", bus.iss_valid, 0);
      check("rst_payload", payload_nonzero(), 0);
      check("rst_disp_ready", bus.disp_ready, 0);
      reset = 1'b0;
      idle();
      tick();
      check("rst_no_issue", bus.iss_valid, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.disp_valid = ($urandom_range(0, 9) < 7);
         bus.disp_rd = TAG_W'($urandom_range(1, 63));
         bus.disp_rs1 = TAG_W'($urandom_range(0, 7));
         bus.disp_rs2 = TAG_W'($urandom_range(0, 7));
         bus.disp_rob = TAG_W'($urandom);
         bus.disp_rs1_ready = 1'($urandom_range(0, 1));
         bus.disp_rs2_ready = 1'($urandom_range(0, 1));
         bus.disp_rs1_val = $urandom;
         bus.disp_rs2_val = $urandom;
         bus.disp_imm = $urandom;
         bus.disp_alu_ctl = 4'($urandom);
         bus.disp_alusrc = 1'($urandom_range(0, 1));
         bus.disp_ls = ($urandom_range(0, 3) == 0);
         for (int p = 0; p < NUM_WAKEUP; p++) begin
            bus.wk_valid[p] = 1'($urandom_range(0, 1));
            bus.wk_tag[p*TAG_W +: TAG_W] = TAG_W'($urandom_range(0, 7));
            bus.wk_val[p*DATA_W +: DATA_W] = $urandom;
         end
         bus.fu_ready = NUM_FU'($urandom);
         flush = ($urandom_range(0, 99) == 0);
         reset = ($urandom_range(0, 299) == 0);
         #1 check("rand_disp_ready", bus.disp_ready,
                  64'(!reset && !flush && mq.size() < DEPTH));
         tick();
      end
      reset = 1'b0;

      // Drain: wake everything, all FUs ready
      idle();
      bus.fu_ready = 3'b111;
      for (int c = 0; c < 40; c++) begin
         for (int p = 0; p < NUM_WAKEUP; p++) set_wk(p, TAG_W'(1 + (c * NUM_WAKEUP + p) % 7), $urandom);
         tick();
      end
      idle();
      tick();
      tick();
      for (int f = 0; f < NUM_FU; f++) check("pending_expectations", exp_q[f].size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 Parameter DEPTH, default 16: number of entries, power of 2, at least 4.
REQ-002 Parameter NUM_FU, default 3: issue ports; FU NUM_FU-1 is the load/store unit, all others are ALUs.
REQ-003 Parameter NUM_WAKEUP, default 4: number of result broadcast ports.
REQ-004 Parameter TAG_W, default 6, and DATA_W, default 32: physical tag width and operand width.
REQ-005 clk  in  1: single clock, rising edge; one clock domain, reset is synchronous and active-high.
REQ-006 reset  in  1: synchronous, active-high.
REQ-007 flush  in  1: clears all entries (mispredict recovery).
REQ-008 disp_valid  in  1, and disp_ready  out  1: dispatch handshake.
REQ-009 disp_rd, disp_rs1, disp_rs2  in  TAG_W each, and disp_rob  in  TAG_W: destination tag, source tags and ROB number.
REQ-010 disp_rs1_ready, disp_rs2_ready  in  1, and disp_rs1_val, disp_rs2_val  in  DATA_W: source readiness and values.
REQ-011 disp_imm  in  DATA_W, disp_alu_ctl  in  4, disp_alusrc  in  1, disp_ls  in  1: immediate and control fields.
REQ-012 wk_valid  in  NUM_WAKEUP, wk_tag  in  NUM_WAKEUP*TAG_W, wk_val  in  NUM_WAKEUP*DATA_W: broadcasts packed as port i at slice i.
REQ-013 fu_ready  in  NUM_FU: FU f accepts an issue at this edge.
REQ-014 iss_valid  out  NUM_FU: issue strobes.
REQ-015 iss_rd, iss_rob  out  NUM_FU*TAG_W; iss_rs1_val, iss_rs2_val, iss_imm  out  NUM_FU*DATA_W; iss_alu_ctl  out  NUM_FU*4; iss_alusrc, iss_ls  out  NUM_FU: issue payloads, all registered.
REQ-016 count  out  log2(DEPTH)+1: registered occupancy.

Function
REQ-017 disp_ready SHALL equal (count < DEPTH) and not flush; a dispatch is accepted when disp_valid and disp_ready are both high at a rising edge.
REQ-018 An accepted dispatch SHALL write into any free entry and receive an age newer than every other resident entry.
REQ-019 At dispatch, a source marked not ready SHALL become ready with the captured value if that same cycle a wk port has valid high and a matching tag.
REQ-020 Each edge, every valid entry with a pending source SHALL capture wk_val from the lowest-index valid wakeup port whose tag matches.
REQ-021 Wakeup tag 0 SHALL be ignored.
REQ-022 An entry is eligible when both sources are ready, or when a pending source is being woken this cycle (bypass); the issued value SHALL be the bypassed value.
REQ-023 Eligibility by FU: disp_ls=1 entries are eligible only for FU NUM_FU-1; disp_ls=0 entries are eligible only for FUs 0..NUM_FU-2.
REQ-024 Selection order: FUs are served in ascending index; each FU with fu_ready=1 takes the oldest eligible entry not taken by a lower FU.
REQ-025 A selected entry SHALL load that FU's iss_* registers, assert its iss_valid for exactly one cycle, and be freed at the same edge.
REQ-026 An FU with fu_ready=0, or with no eligible entry, SHALL drive iss_valid=0 next cycle; its payload is don't-care and SHALL hold its previous value.
REQ-027 Minimum latency: dispatch accepted at edge E with ready sources SHALL give iss_valid high after edge E+1; an entry is never issued at the edge it is written.
REQ-028 count(next) = count + accepted dispatch - issues; simultaneous dispatch and issue of another entry at the edge SHALL leave count unchanged.
REQ-029 Full: when count=DEPTH, disp_ready=0 even if an issue occurs in the same cycle.
REQ-030 Age ordering SHALL remain correct across arbitrarily long runs; no wrap-around effect.
REQ-031 flush SHALL, at the edge, invalidate all entries, set count=0 and iss_valid=0; flush takes priority over dispatch, wakeup and issue in the same cycle.

Reset
REQ-032 While reset is high at an edge, all entries SHALL be invalid, count=0, iss_valid=0, and all iss_* payloads=0; disp_ready SHALL be 0 during reset and 1 on the first cycle after.
REQ-033 Reset asserted mid-operation SHALL discard all entries with no issue afterward; reset has priority over flush.

Verification
REQ-034 Basic ALU issue: dispatch rd=10, rs1=11 (1), rs2=12 (2), both ready, alu_ctl=0010, rob=15, fu_ready=001 -> iss_valid[0]=1 one cycle later with rs1_val=1, rs2_val=2, rob=15.
REQ-035 Load/store routing: dispatch ls=1, rd=20, rs1=21 (3), fu_ready=001 -> no issue; fu_ready goes to 100 -> issued on FU2 with rs1_val=3.
REQ-036 Wakeup: rd=30, rs1=31 not ready, rs2=4 ready; wk port 1 carries tag=31, val=1 -> issues one cycle after the broadcast with rs1_val=1; a same-cycle tag-31 match on ports 0 and 2 with different values -> port-0 value wins.
REQ-037 Age and fill: fill DEPTH=16 entries all ready with fu_ready=0 -> count=16, disp_ready=0; enable FU0 only -> issue in dispatch order, one per cycle, count falls to 0.
REQ-038 Two ALUs: two ready ALU entries, fu_ready=011 -> both issue in the same cycle, the oldest on FU0.
REQ-039 Flush/reset: flush asserted with disp_valid=1 and 5 entries resident -> count=0, no iss_valid next cycle, and the dispatch is dropped; repeat with reset -> all outputs are 0.
